// File: rtl/raymarch_pkg.sv
// Shared definitions for the raymarch frame writer: default geometry,
// sequencer states and the RGB332 pixel packing.
package raymarch_pkg;

    localparam int CORDW         = 10;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int ADDR_W        = 19;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    function automatic logic [7:0] rgb332(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

endpackage

// File: rtl/raymarch_pixel_writer_if.sv
// Framebuffer write port: valid/ready handshake carrying a linear address
// and one packed RGB332 pixel.
interface raymarch_pixel_writer_if #(
    parameter int ADDR_W = raymarch_pkg::ADDR_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; push and pop in one cycle are both honoured,
// including at full. Head data reads as zero while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/raymarch_pixel_writer.sv
// Frame sequencer feeding a fixed-latency raymarcher and writing its colours
// to the framebuffer; issue is credit-limited because the pipe cannot stall.
module raymarch_pixel_writer #(
    parameter int CORDW         = raymarch_pkg::CORDW,
    parameter int SCREEN_WIDTH  = raymarch_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = raymarch_pkg::SCREEN_HEIGHT,
    parameter int ADDR_W        = raymarch_pkg::ADDR_W,
    parameter int LATENCY       = 12,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CORDW-1:0] o_pixel_x,
    output logic [CORDW-1:0] o_pixel_y,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_green,
    input  logic [7:0]       i_blue,
    raymarch_pixel_writer_if.master wr
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    raymarch_pkg::state_e state_q, state_d;
    logic                 done_q, done_d;
    logic [CORDW-1:0]     x_q, y_q, pix_x_q, pix_y_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     fifo_count, fifo_count_next;
    logic [SUM_W-1:0]     credit_sum;
    logic [ADDR_W:0]      tag_q [LATENCY];
    logic                 issue, last_pixel, tag_exit;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W+7:0]    fifo_head;

    assign credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight_q);
    assign issue      = (state_q == raymarch_pkg::ISSUE) && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign last_pixel = (x_q == CORDW'(SCREEN_WIDTH - 1)) && (y_q == CORDW'(SCREEN_HEIGHT - 1));
    assign tag_exit   = tag_q[LATENCY-1][ADDR_W];

    // Coordinates are presented in the issue cycle itself so that the
    // colour lines up with the tag leaving the last shift stage.
    assign o_pixel_x = issue ? x_q : pix_x_q;
    assign o_pixel_y = issue ? y_q : pix_y_q;

    assign fifo_push       = tag_exit;
    assign fifo_pop        = wr.wr_valid && wr.wr_ready;
    assign fifo_count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    sync_fifo_fwft #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({tag_q[LATENCY-1][ADDR_W-1:0], raymarch_pkg::rgb332(i_red, i_green, i_blue)}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr.wr_valid = !fifo_empty;
    assign wr.wr_addr  = fifo_head[ADDR_W+7:8];
    assign wr.wr_data  = fifo_head[7:0];

    assign o_busy       = (state_q != raymarch_pkg::IDLE);
    assign o_frame_done = done_q;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !tag_exit) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && tag_exit) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Drain completion looks at next-cycle occupancy so busy drops together
    // with the done pulse, one cycle after the last write handshake.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            raymarch_pkg::IDLE:  if (i_start) state_d = raymarch_pkg::ISSUE;
            raymarch_pkg::ISSUE: if (issue && last_pixel) state_d = raymarch_pkg::DRAIN;
            raymarch_pkg::DRAIN: begin
                if (inflight_d == '0 && fifo_count_next == '0) begin
                    state_d = raymarch_pkg::IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = raymarch_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= raymarch_pkg::IDLE;
            done_q     <= 1'b0;
            inflight_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            if (state_q == raymarch_pkg::IDLE) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (issue) begin
                pix_x_q <= x_q;
                pix_y_q <= y_q;
                addr_q  <= addr_q + ADDR_W'(1);
                if (x_q == CORDW'(SCREEN_WIDTH - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == CORDW'(SCREEN_HEIGHT - 1)) ? '0 : y_q + CORDW'(1);
                end else begin
                    x_q <= x_q + CORDW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= issue ? {1'b1, addr_q} : '0;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop));

endmodule
